// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: lock-state type and pointer helper for mem_arbiter.
// Imported by the arbiter top.
package mem_arbiter_pkg;

  typedef enum logic {
    LK_IDLE  = 1'b0,
    LK_OWNED = 1'b1
  } lock_state_e;

  function automatic int next_port(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arb_defs.vh
// mem_arb_defs: bank encodings and port-id width for the memory arbiter.
// Shared by the arbiter and any block that tags memory traffic by port.
`ifndef MEM_ARB_DEFS_VH
`define MEM_ARB_DEFS_VH

`define BANK_BRAM  1'b0
`define BANK_SPRAM 1'b1

`define MEM_ARB_ID_W(n) (((n) > 1) ? $clog2(n) : 1)

`endif

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant.
// Rotates valid by ptr, isolates the lowest set bit, rotates back.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant
);

  logic [2*N-1:0] dbl_v;
  logic [2*N-1:0] dbl_g;
  logic [N-1:0]   rot_v;
  logic [N-1:0]   rot_g;

  // Rotate so ptr is bit 0, pick lowest, rotate back.
  always_comb begin
    dbl_v = {valid, valid} >> ptr;
    rot_v = dbl_v[N-1:0];
    rot_g = rot_v & (-rot_v);
    dbl_g = {rot_g, rot_g} << ptr;
    grant = dbl_g[2*N-1:N];
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port arbiter onto shared BRAM/SPRAM,
// with read tracking by port/bank. Define MEM_ARB_LOCK_EN for grant lock.
`include "mem_arb_defs.vh"

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int MEM_SELECT_BITS = 4,
  parameter int ADDR_BITS       = 8,
  parameter int SP_ADDR_BITS    = 14,
  parameter int DATA_BITS       = 16,
  parameter int RD_LATENCY      = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0]                 req_we,
  input  logic [NUM_PORTS-1:0]                 req_bank,
  input  logic [NUM_PORTS-1:0]                 req_lock,
  input  logic [NUM_PORTS*MEM_SELECT_BITS-1:0] req_sel,
  input  logic [NUM_PORTS*SP_ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0]       req_wdata,
  output logic [NUM_PORTS-1:0]                 rsp_valid,
  output logic [DATA_BITS-1:0]                 rsp_data,
  output logic [MEM_SELECT_BITS-1:0]           mem_select,
  output logic [ADDR_BITS-1:0]                 rd_addr,
  output logic [ADDR_BITS-1:0]                 wr_addr,
  output logic [SP_ADDR_BITS-1:0]              sp_addr,
  output logic [DATA_BITS-1:0]                 data_in,
  output logic                                 rd_en,
  output logic                                 wr_en,
  output logic                                 bram_or_spram,
  input  logic [DATA_BITS-1:0]                 b_data_out,
  input  logic [DATA_BITS-1:0]                 sp_data_out
);

  localparam int IDW = `MEM_ARB_ID_W(NUM_PORTS);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] port;
    logic           bank;
  } track_t;

  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic [NUM_PORTS-1:0] grant;
  logic                 locked;
  logic                 xfer;

  logic [IDW-1:0]             gnt_idx;
  logic                       g_we;
  logic                       g_bank;
  logic [MEM_SELECT_BITS-1:0] g_sel;
  logic [SP_ADDR_BITS-1:0]    g_addr;
  logic [DATA_BITS-1:0]       g_wdata;

  logic                       rd_en_q, rd_en_d;
  logic                       wr_en_q, wr_en_d;
  logic [MEM_SELECT_BITS-1:0] sel_q, sel_d;
  logic [SP_ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]       wdata_q, wdata_d;
  logic                       bank_q, bank_d;
  logic [IDW-1:0]             port_q, port_d;

  track_t track_q [RD_LATENCY];
  track_t track_d [RD_LATENCY];
  track_t tail;

  rr_arbiter #(
    .N   (NUM_PORTS),
    .IDW (IDW)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_gnt)
  );

`ifdef MEM_ARB_LOCK_EN
  lock_state_e          lk_state_q, lk_state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [NUM_PORTS-1:0] owner_oh;
  logic                 g_lock;

  // Owner takes the grant while it keeps req_lock high.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      owner_oh[i] = (owner_q == IDW'(i));
    end
    locked = (lk_state_q == LK_OWNED)
          && |(req_lock & owner_oh);
    grant  = locked ? owner_oh : arb_gnt;
    g_lock = |(req_lock & grant);
  end

  // Lock FSM: enter on a locked transfer, leave when lock drops.
  always_comb begin
    lk_state_d = lk_state_q;
    owner_d    = owner_q;
    unique case (lk_state_q)
      LK_IDLE: begin
        if (xfer && g_lock) begin
          lk_state_d = LK_OWNED;
          owner_d    = gnt_idx;
        end
      end
      LK_OWNED: begin
        if (!locked) begin
          if (xfer && g_lock) begin
            owner_d = gnt_idx;
          end else begin
            lk_state_d = LK_IDLE;
          end
        end
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_state_q <= LK_IDLE;
      owner_q    <= '0;
    end else begin
      lk_state_q <= lk_state_d;
      owner_q    <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign locked      = 1'b0;
  assign grant       = arb_gnt;
`endif

  assign req_ready = reset ? '0 : grant;
  assign xfer      = |(req_valid & req_ready);

  // Decode the granted port and pick out its request fields.
  always_comb begin
    gnt_idx = '0;
    g_we    = 1'b0;
    g_bank  = 1'b0;
    g_sel   = '0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        gnt_idx = IDW'(i);
        g_we    = req_we[i];
        g_bank  = req_bank[i];
        g_sel   = req_sel[i*MEM_SELECT_BITS +: MEM_SELECT_BITS];
        g_addr  = req_addr[i*SP_ADDR_BITS +: SP_ADDR_BITS];
        g_wdata = req_wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Pointer moves past the winner; frozen while a lock holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && !locked) begin
      rr_ptr_d = IDW'(next_port(int'(gnt_idx), NUM_PORTS));
    end
  end

  // Issue stage: strobes pulse on a transfer, fields hold otherwise.
  always_comb begin
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bank_d  = bank_q;
    port_d  = port_q;
    if (xfer) begin
      rd_en_d = !g_we;
      wr_en_d = g_we;
      sel_d   = g_sel;
      addr_d  = g_addr;
      wdata_d = g_wdata;
      bank_d  = g_bank;
      port_d  = gnt_idx;
    end
  end

  // Tracking pipe: issued reads ride along with the memory latency.
  always_comb begin
    track_d[0] = '{vld: rd_en_q, port: port_q, bank: bank_q};
    for (int k = 1; k < RD_LATENCY; k++) begin
      track_d[k] = track_q[k-1];
    end
  end

  // Pointer, issue and tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bank_q   <= 1'b0;
      port_q   <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        track_q[k] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bank_q   <= bank_d;
      port_q   <= port_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        track_q[k] <= track_d[k];
      end
    end
  end

  assign tail = track_q[RD_LATENCY-1];

  // Response: strobe the issuing port, mux data by tracked bank.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_valid[i] = tail.vld && (tail.port == IDW'(i));
    end
    if (tail.vld) begin
      rsp_data = (tail.bank == `BANK_SPRAM) ? sp_data_out
                                            : b_data_out;
    end
  end

  assign mem_select    = sel_q;
  assign rd_addr       = addr_q[ADDR_BITS-1:0];
  assign wr_addr       = addr_q[ADDR_BITS-1:0];
  assign sp_addr       = addr_q;
  assign data_in       = wdata_q;
  assign rd_en         = rd_en_q;
  assign wr_en         = wr_en_q;
  assign bram_or_spram = bank_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 1-cycle memory model.
// Default parameters: 2 ports, RD_LATENCY = 1.
module tb_mem_arbiter;

  localparam int NP  = 2;
  localparam int MSB = 4;
  localparam int AB  = 8;
  localparam int SPB = 14;
  localparam int DB  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req_valid, req_ready, req_we;
  logic [NP-1:0]   req_bank, req_lock, rsp_valid;
  logic [NP*MSB-1:0] req_sel;
  logic [NP*SPB-1:0] req_addr;
  logic [NP*DB-1:0]  req_wdata;
  logic [DB-1:0]   rsp_data, data_in;
  logic [DB-1:0]   b_data_out, sp_data_out;
  logic [MSB-1:0]  mem_select;
  logic [AB-1:0]   rd_addr, wr_addr;
  logic [SPB-1:0]  sp_addr;
  logic            rd_en, wr_en, bram_or_spram;

  logic [DB-1:0] bmem  [256];
  logic [DB-1:0] spmem [256];

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_bank      (req_bank),
    .req_lock      (req_lock),
    .req_sel       (req_sel),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .mem_select    (mem_select),
    .rd_addr       (rd_addr),
    .wr_addr       (wr_addr),
    .sp_addr       (sp_addr),
    .data_in       (data_in),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .bram_or_spram (bram_or_spram),
    .b_data_out    (b_data_out),
    .sp_data_out   (sp_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: one cycle from rd_en to data.
  always @(posedge clk) begin
    if (wr_en) begin
      if (bram_or_spram) spmem[sp_addr[7:0]] <= data_in;
      else               bmem[wr_addr] <= data_in;
    end
    if (rd_en) begin
      b_data_out  <= bmem[rd_addr];
      sp_data_out <= spmem[sp_addr[7:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we,
                          input logic bank, input logic [MSB-1:0] sel,
                          input logic [SPB-1:0] addr,
                          input logic [DB-1:0] wd);
    req_we[p]                = we;
    req_bank[p]              = bank;
    req_sel[p*MSB +: MSB]    = sel;
    req_addr[p*SPB +: SPB]   = addr;
    req_wdata[p*DB +: DB]    = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_bank = '0; req_lock = '0;
    req_sel = '0; req_addr = '0; req_wdata = '0;
    step(); step();
    req_valid = 2'b01;
    #1;
    n_cmp++; if ({rd_en, wr_en, bram_or_spram} !== 3'b000) begin
      n_bad++; $display("FAIL rst_strobes: got %b want 000", {rd_en, wr_en, bram_or_spram}); end
    n_cmp++; if ({mem_select, rd_addr, wr_addr} !== 20'h0) begin
      n_bad++; $display("FAIL rst_addr: got %h want 0", {mem_select, rd_addr, wr_addr}); end
    n_cmp++; if ({sp_addr, data_in} !== 30'h0) begin
      n_bad++; $display("FAIL rst_sp_data: got %h want 0", {sp_addr, data_in}); end
    n_cmp++; if ({rsp_valid, rsp_data} !== 18'h0) begin
      n_bad++; $display("FAIL rst_rsp: got %h want 0", {rsp_valid, rsp_data}); end
    n_cmp++; if (req_ready !== 2'b00) begin
      n_bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL post_rst_ready: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    step(); step(); step();
  endtask

  task automatic test_single_read();
    set_port(1, 1'b0, 1'b0, 4'h0, 14'h0001, 16'h0);
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL rd_ready: got %b want 10", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if ({rd_en, wr_en} !== 2'b10 || rd_addr !== 8'h01) begin
      n_bad++; $display("FAIL rd_strobe: got en=%b addr=%h want 10/01", {rd_en, wr_en}, rd_addr); end
    n_cmp++; if (rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL rd_early_rsp: got %b want 00", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 16'h1234) begin
      n_bad++; $display("FAIL rd_rsp: got %b/%h want 10/1234", rsp_valid, rsp_data); end
    step();
    n_cmp++; if (rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL rd_rsp_width: got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [NP-1:0] exp;
    reset = 1'b1; req_valid = '0;
    step();
    set_port(0, 1'b0, 1'b0, 4'h0, 14'h0002, 16'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 14'h0003, 16'h0);
    reset = 1'b0; req_valid = 2'b11;
    #1;
    exp = 2'b01;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (req_ready !== exp) begin
        n_bad++; $display("FAIL cont_alt%0d: got %b want %b", k, req_ready, exp); end
      step();
      exp = ~exp;
    end
    req_valid = 2'b01;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (req_ready !== 2'b01) begin
        n_bad++; $display("FAIL cont_solo%0d: got %b want 01", k, req_ready); end
      step();
    end
    req_valid = '0;
    step(); step(); step();
  endtask

  task automatic test_bank_tracking();
    set_port(0, 1'b0, 1'b1, 4'h0, 14'h0020, 16'h0);
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL bank_rdy0: got %b want 01", req_ready); end
    step();
    set_port(1, 1'b0, 1'b0, 4'h0, 14'h0021, 16'h0);
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL bank_rdy1: got %b want 10", req_ready); end
    n_cmp++; if (rd_en !== 1'b1 || bram_or_spram !== 1'b1 || sp_addr !== 14'h0020) begin
      n_bad++; $display("FAIL bank_issue_sp: got %b/%b/%h want 1/1/0020", rd_en, bram_or_spram, sp_addr); end
    step();
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_data !== 16'hBEEF) begin
      n_bad++; $display("FAIL bank_rsp_sp: got %b/%h want 01/beef", rsp_valid, rsp_data); end
    step();
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 16'h0005) begin
      n_bad++; $display("FAIL bank_rsp_b: got %b/%h want 10/0005", rsp_valid, rsp_data); end
    step();
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_data !== 16'h0) begin
      n_bad++; $display("FAIL bank_idle: got %b/%h want 00/0000", rsp_valid, rsp_data); end
  endtask

  task automatic test_write();
    set_port(0, 1'b1, 1'b0, 4'h3, 14'h0010, 16'h00AA);
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin
      n_bad++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    step();
    req_valid = '0;
    set_port(0, 1'b0, 1'b0, 4'h0, 14'h0, 16'h0);
    n_cmp++; if ({wr_en, rd_en} !== 2'b10 || mem_select !== 4'h3) begin
      n_bad++; $display("FAIL wr_strobe: got %b/%h want 10/3", {wr_en, rd_en}, mem_select); end
    n_cmp++; if (wr_addr !== 8'h10 || data_in !== 16'h00AA) begin
      n_bad++; $display("FAIL wr_fields: got %h/%h want 10/00aa", wr_addr, data_in); end
    step();
    n_cmp++; if (wr_en !== 1'b0 || mem_select !== 4'h3 || data_in !== 16'h00AA) begin
      n_bad++; $display("FAIL wr_hold: got %b/%h/%h want 0/3/00aa", wr_en, mem_select, data_in); end
    n_cmp++; if (rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL wr_no_rsp1: got %b want 00", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 2'b00) begin
      n_bad++; $display("FAIL wr_no_rsp2: got %b want 00", rsp_valid); end
    set_port(1, 1'b0, 1'b0, 4'h3, 14'h0010, 16'h0);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    step();
    n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 16'h00AA) begin
      n_bad++; $display("FAIL wr_readback: got %b/%h want 10/00aa", rsp_valid, rsp_data); end
    step();
  endtask

  task automatic test_reset_mid_read();
    set_port(1, 1'b0, 1'b1, 4'h5, 14'h0001, 16'h5A5A);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    reset = 1'b1;
    n_cmp++; if (rd_en !== 1'b1 || mem_select !== 4'h5 || data_in !== 16'h5A5A) begin
      n_bad++; $display("FAIL mid_issue: got %b/%h/%h want 1/5/5a5a", rd_en, mem_select, data_in); end
    step();
    n_cmp++; if ({rd_en, wr_en, bram_or_spram, mem_select} !== 7'h0) begin
      n_bad++; $display("FAIL mid_rst_ctl: got %h want 0", {rd_en, wr_en, bram_or_spram, mem_select}); end
    n_cmp++; if ({sp_addr, data_in, rd_addr} !== 38'h0) begin
      n_bad++; $display("FAIL mid_rst_data: got %h want 0", {sp_addr, data_in, rd_addr}); end
    n_cmp++; if ({rsp_valid, rsp_data} !== 18'h0) begin
      n_bad++; $display("FAIL mid_rst_rsp: got %h want 0", {rsp_valid, rsp_data}); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rsp_valid !== 2'b00) begin
        n_bad++; $display("FAIL mid_ghost%0d: got %b want 00", k, rsp_valid); end
      step();
    end
  endtask

  task automatic test_lock();
    reset = 1'b1; req_valid = '0;
    step();
    reset = 1'b0;
    set_port(1, 1'b0, 1'b0, 4'h0, 14'h0030, 16'h0);
    req_lock  = 2'b01;
    req_valid = 2'b11;
`ifdef MEM_ARB_LOCK_EN
    for (int k = 0; k < 4; k++) begin
      set_port(0, 1'b0, 1'b0, 4'h0, SPB'(k), 16'h0);
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin
        n_bad++; $display("FAIL lock_hold%0d: got %b want 01", k, req_ready); end
      step();
    end
    req_lock  = 2'b00;
    req_valid = 2'b10;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin
      n_bad++; $display("FAIL lock_release: got %b want 10", req_ready); end
    step();
`else
    set_port(0, 1'b0, 1'b0, 4'h0, 14'h0031, 16'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL nolock_alt%0d: got %b", k, req_ready); end
      step();
    end
`endif
    req_lock  = '0;
    req_valid = '0;
    step(); step(); step();
  endtask

  initial begin
    b_data_out  = '0;
    sp_data_out = '0;
    for (int i = 0; i < 256; i++) begin
      bmem[i]  = 16'hF000 | 16'(i);
      spmem[i] = 16'hE000 | 16'(i);
    end
    bmem[8'h01]  = 16'h1234;
    bmem[8'h20]  = 16'h1111;
    bmem[8'h21]  = 16'h0005;
    spmem[8'h20] = 16'hBEEF;
    spmem[8'h21] = 16'h2222;
    test_reset();
    test_single_read();
    test_contention();
    test_bank_tracking();
    test_write();
    test_reset_mid_read();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port arbiter between memory requesters (UART controller, compute cores) and the shared BRAM/SPRAM array. It replaces the fixed two-way `active`-based mux with round-robin arbitration and a valid/ready request handshake. It also tracks each read through the memory latency, returning data only to the port that issued it, with the BRAM/SPRAM output selected by the tracked bank.

## Interface
- NUM_PORTS, 2, number of requester ports (≥1); port 0 is conventionally the UART controller
- MEM_SELECT_BITS, 4, BRAM block-select width
- ADDR_BITS, 8, BRAM word address width
- SP_ADDR_BITS, 14, SPRAM address width; request address width (BRAM uses low ADDR_BITS)
- DATA_BITS, 16, data width
- RD_LATENCY, 1, memory read latency in cycles, counted from registered rd_en (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant, combinational; at most one bit high
- req_we  in  NUM_PORTS  1 = write, 0 = read
- req_bank  in  NUM_PORTS  0 = BRAM, 1 = SPRAM
- req_lock  in  NUM_PORTS  hold grant (used only with MEM_ARB_LOCK_EN)
- req_sel  in  NUM_PORTS*MEM_SELECT_BITS  block select, port i at [i*W +: W]
- req_addr  in  NUM_PORTS*SP_ADDR_BITS  address
- req_wdata  in  NUM_PORTS*DATA_BITS  write data
- rsp_valid  out  NUM_PORTS  one-cycle read-data strobe to issuing port
- rsp_data  out  DATA_BITS  read data, shared, qualified by rsp_valid
- mem_select  out  MEM_SELECT_BITS  to BRAM/SPRAM
- rd_addr, wr_addr  out  ADDR_BITS  BRAM addresses
- sp_addr  out  SP_ADDR_BITS  SPRAM address
- data_in  out  DATA_BITS  write data
- rd_en, wr_en  out  1  strobes
- bram_or_spram  out  1  bank select
- b_data_out, sp_data_out  in  DATA_BITS  memory read data

## Operation
- Arbitration: each cycle, the winner is the first port with req_valid high, searching from rr_ptr upward modulo NUM_PORTS. req_ready is one-hot on the winner and zero if no port is valid.
- A transfer occurs when req_valid[i] && req_ready[i]. On a transfer, rr_ptr ← (i+1) mod NUM_PORTS. With no transfer, rr_ptr holds.
- Issue stage: a transfer registers the memory outputs from port i's fields. rd_en = !we, wr_en = we, rd_addr = wr_addr = addr[ADDR_BITS-1:0], sp_addr = addr, bram_or_spram = bank.
- With no transfer, rd_en = wr_en = 0 and the other memory outputs hold their last values.
- Read tracking: a shift register of depth RD_LATENCY holds {valid, port id, bank}. It is loaded at issue of a read and advances every cycle.
- At the tail, rsp_valid[port] = 1 and rsp_data = bank ? sp_data_out : b_data_out.
- Writes produce no response.
- One transfer is accepted per cycle, reads and writes interleaved freely. There is no backpressure on responses; requesters must always accept rsp_valid.
- NUM_PORTS = 1: req_ready = req_valid[0].
- Simultaneous response and new issue on the same cycle are independent and both proceed.

## Timing
- Accept → memory strobe: 1 cycle.
- Read accept in cycle t → rsp_valid in cycle t+1+RD_LATENCY, exactly one cycle wide.
- Back-to-back reads give back-to-back responses in issue order.
- Reset values: rr_ptr = 0, tracking pipe all invalid, rsp_valid = 0, rsp_data = 0, rd_en = wr_en = 0, all address/data/select outputs 0, bram_or_spram = 0.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid follows reset. req_ready is driven normally in the first cycle after reset deasserts.
- req_ready depends combinationally on req_valid (and on req_lock when enabled). Requesters must not make req_valid depend on req_ready.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - A port whose transfer completes with req_lock high becomes owner.
  - While the owner holds req_lock, only the owner can be granted, even if its req_valid is low; other ports see req_ready = 0.
  - Ownership ends in the cycle req_lock drops. This replaces the old controller `active` override for multi-cycle UART operations.
  - rr_ptr is not updated while locked.
- Not defined: req_lock is ignored, and the port remains present for a stable interface.

## Structure
- Include file mem_arb_defs.vh holds the bank encodings (BANK_BRAM = 0, BANK_SPRAM = 1) and the port-id width macro ($clog2 with a minimum of 1).
- Sub-module rr_arbiter: a combinational rotate-priority-rotate one-hot grant from {valid, rr_ptr}, reused by future DMA blocks.
- mem_arbiter contains the issue registers, the tracking pipe, the lock logic and the response mux.

## Test plan
- Single read: port 1 reads BRAM sel 0 addr 0x01 holding 0x1234 (RD_LATENCY = 1). Expect rd_en 1 cycle after accept, then rsp_valid = 2'b10 with rsp_data = 0x1234 one cycle later.
- Contention: both ports valid continuously after reset. Grants alternate 0,1,0,1. With port 1 dropped, port 0 is granted every cycle.
- Bank tracking: a SPRAM read (sp_data_out = 0xBEEF) followed next cycle by a BRAM read (b_data_out = 0x0005). Responses arrive 0xBEEF then 0x0005, with no mixing.
- Write: port 0 writes 0x00AA to sel 3 addr 0x10. Expect wr_en = 1, mem_select = 3, wr_addr = 0x10, data_in = 0x00AA, and no rsp_valid.
- Reset mid-read: assert reset in the cycle after a read accept. Expect no rsp_valid ever, and all outputs 0 during reset.
- Lock (macro defined): port 0 locks and issues 4 reads at addresses 0–3 while port 1 stays valid. Port 1's req_ready stays 0 until lock drops, then port 1 is granted the next cycle.
